// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier with WIDTH-bit operands and a 2*WIDTH-bit
// product. Signed operands are converted to magnitudes when the operation is
// accepted, multiplied as unsigned values, and the sign is applied when the
// result is written.
//
// Handshake: start (with signed_mode, a and b) is sampled only on an edge
// where busy=0. It is ignored while busy=1. done pulses for exactly one cycle.
// product is valid from the done cycle and is held until the next done.
module mult_seq_param #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic [IW-1:0]   iter;
  logic            neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mplier_next;
  logic [IW-1:0]    iter_next;
  logic             last_iter;

  // Operand magnitudes. The most negative value maps onto 2^(WIDTH-1), which
  // is still representable as an unsigned WIDTH-bit number.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_mode && a[WIDTH-1]) a_mag = ~a + 1'b1;
    if (signed_mode && b[WIDTH-1]) b_mag = ~b + 1'b1;
  end

  // Loop exit is judged on the values this RUN edge writes, so an early exit
  // still executes at least one iteration.
  always_comb begin
    mplier_next = mplier >> 1;
    iter_next   = iter + 1'b1;
    last_iter   = (iter_next == IW'(WIDTH)) ||
                  (EARLY_EXIT && (mplier_next == '0));
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign busy = (state != IDLE);

  // Datapath: accept operands, shift-add iterations, sign fix-up and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      iter    <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            iter   <= '0;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          iter   <= iter_next;
        end
        FINISH: begin
          product <= neg ? (~acc + 1'b1) : acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
